// File: rtl/ram_stream_reader_if.sv
// Reader-side bundle: burst control, registered-read RAM port and output stream.
// RAM_STREAM_READER_ABORT_EN adds the abort input.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
`ifdef RAM_STREAM_READER_ABORT_EN
  logic                  abort;

  modport master (
    input  start, start_addr, length, ram_data_out, m_ready, abort,
    output busy, done, ram_addr_r, m_data, m_valid
  );
  modport slave (
    output start, start_addr, length, ram_data_out, m_ready, abort,
    input  busy, done, ram_addr_r, m_data, m_valid
  );
`else
  modport master (
    input  start, start_addr, length, ram_data_out, m_ready,
    output busy, done, ram_addr_r, m_data, m_valid
  );
  modport slave (
    output start, start_addr, length, ram_data_out, m_ready,
    input  busy, done, ram_addr_r, m_data, m_valid
  );
`endif
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a burst of RAM words; first word valid 3 cycles after start, 1 word/cycle, stalls on m_ready=0
// via a 2-entry head/skid buffer. RAM_STREAM_READER_ABORT_EN adds burst abort.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input logic                clk,
  input logic                reset,
  ram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] head_data, skid_data;
  logic                  head_vld, skid_vld;
  logic [1:0]            level;
  logic                  xfer, issue, accept, zero_start, last_xfer, abort_req;

  // A read is issued while its address sits on ram_addr_r; its data lands one cycle later.
  assign xfer       = head_vld & bus.m_ready;
  assign level      = 2'(head_vld) + 2'(skid_vld) + 2'(inflight);
  assign issue      = (state == RUN) && (remaining != '0) && (level <= 2'd1 + 2'(xfer));
  assign accept     = (state == IDLE) && bus.start;
  assign zero_start = accept && (bus.length == '0);
  assign last_xfer  = (state == DRAIN) && xfer && !inflight && !skid_vld;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign abort_req = (state != IDLE) && bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !zero_start) state_nxt = RUN;
      RUN:     if (issue && remaining == LEN_ONE) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_req) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      addr_q    <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
      head_data <= '0;
      head_vld  <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= zero_start | last_xfer | abort_req;
      inflight <= issue;

      if (accept && !zero_start) begin
        addr_q    <= bus.start_addr;
        remaining <= bus.length;
      end else if (issue) begin
        addr_q    <= addr_q + ADDR_ONE;
        remaining <= remaining - LEN_ONE;
      end

      // The issue rule guarantees a push never meets a full buffer without a pop.
      if (xfer) begin
        if (skid_vld) begin
          head_data <= skid_data;
          skid_vld  <= inflight;
          if (inflight) skid_data <= bus.ram_data_out;
        end else begin
          head_vld <= inflight;
          if (inflight) head_data <= bus.ram_data_out;
        end
      end else if (inflight) begin
        if (!head_vld) begin
          head_data <= bus.ram_data_out;
          head_vld  <= 1'b1;
        end else begin
          skid_data <= bus.ram_data_out;
          skid_vld  <= 1'b1;
        end
      end

      if (abort_req) begin
        remaining <= '0;
        inflight  <= 1'b0;
        head_vld  <= 1'b0;
        skid_vld  <= 1'b0;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.ram_addr_r = addr_q;
  assign bus.m_data     = head_data;
  assign bus.m_valid    = head_vld;
endmodule
